// File: rtl/fmcrop.sv
// fmcrop: runtime-configurable feature-map crop stage.
//
// Consumes a row-major, channel-folded feature-map stream. There are CF =
// NUM_CHANNELS/SIMD beats per pixel. Only beats inside the window
// XON<=x<XOFF, YON<=y<YOFF are forwarded. All other beats are accepted and
// dropped.
//
// Window registers are written through a decoded register port. Each write
// lands in a staged copy. The staged copy becomes active only at a frame
// boundary, so a frame is never cropped with mixed geometry.
//
// Ports:
//   ap_clk, ap_rst         clock; asynchronous active-high reset
//   we, wa, wd             register write strobe, byte address, data
//                          word map (wa[4:2]): 0=XON 1=XOFF 2=XEND
//                                              3=YON 4=YOFF 5=YEND
//   s_axis_tvalid/tready/tdata   input beat stream
//   m_axis_tvalid/tready/tdata   output beat stream (2-entry skid buffer,
//                                registered output, latency 1)
module fmcrop #(
    parameter int unsigned XCOUNTER_BITS = 8,
    parameter int unsigned YCOUNTER_BITS = 8,
    parameter int unsigned NUM_CHANNELS  = 4,
    parameter int unsigned SIMD          = 2,
    parameter int unsigned ELEM_BITS     = 8,
    parameter int unsigned INIT_XON      = 1,
    parameter int unsigned INIT_XOFF     = 9,
    parameter int unsigned INIT_XEND     = 9,
    parameter int unsigned INIT_YON      = 1,
    parameter int unsigned INIT_YOFF     = 9,
    parameter int unsigned INIT_YEND     = 9,
    localparam int unsigned STREAM_BITS  = 8 * ((SIMD * ELEM_BITS + 7) / 8)
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic                   we,
    input  logic [4:0]             wa,
    input  logic [31:0]            wd,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tvalid,
    input  logic [STREAM_BITS-1:0] s_axis_tdata,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tvalid,
    output logic [STREAM_BITS-1:0] m_axis_tdata
);

    localparam int unsigned CF    = NUM_CHANNELS / SIMD;
    localparam int unsigned CBITS = (CF > 1) ? $clog2(CF) : 1;

    // Position counters
    logic [CBITS-1:0]         c_q;
    logic [XCOUNTER_BITS-1:0] x_q;
    logic [YCOUNTER_BITS-1:0] y_q;

    // Active geometry
    logic [XCOUNTER_BITS-1:0] xon_q, xoff_q, xend_q;
    logic [YCOUNTER_BITS-1:0] yon_q, yoff_q, yend_q;

    // Staged geometry
    logic [XCOUNTER_BITS-1:0] sxon_q, sxoff_q, sxend_q;
    logic [YCOUNTER_BITS-1:0] syon_q, syoff_q, syend_q;
    logic                     pend_q;

    // Skid buffer: head_q drives the output directly, skid_q holds a second beat
    logic [STREAM_BITS-1:0] head_q, head_d;
    logic [STREAM_BITS-1:0] skid_q, skid_d;
    logic [1:0]             cnt_q, cnt_d;
    logic                   vld_q, rdy_q;

    logic accept, keep, push, pop;
    logic c_last, x_last, y_last, frame_last, at_start, load, wr_hit;
    logic unused_bits;

    assign unused_bits = ^{wa[1:0], wd};

    assign accept     = s_axis_tvalid & rdy_q;
    assign c_last     = (c_q == CBITS'(CF - 1));
    assign x_last     = (x_q == xend_q);
    assign y_last     = (y_q == yend_q);
    assign frame_last = c_last & x_last & y_last;
    assign at_start   = (c_q == '0) & (x_q == '0) & (y_q == '0);
    assign keep       = (x_q >= xon_q) & (x_q < xoff_q) &
                        (y_q >= yon_q) & (y_q < yoff_q);
    assign push       = accept & keep;
    assign pop        = vld_q & m_axis_tready;
    assign wr_hit     = we & (wa[4:2] <= 3'd5);

    // Reload either while idle at pixel (0,0), or together with the last
    // beat of a frame, so the next frame starts on the new geometry.
    assign load = pend_q & ((at_start & ~accept) | (accept & frame_last));

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            c_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            xon_q   <= XCOUNTER_BITS'(INIT_XON);
            xoff_q  <= XCOUNTER_BITS'(INIT_XOFF);
            xend_q  <= XCOUNTER_BITS'(INIT_XEND);
            yon_q   <= YCOUNTER_BITS'(INIT_YON);
            yoff_q  <= YCOUNTER_BITS'(INIT_YOFF);
            yend_q  <= YCOUNTER_BITS'(INIT_YEND);
            sxon_q  <= XCOUNTER_BITS'(INIT_XON);
            sxoff_q <= XCOUNTER_BITS'(INIT_XOFF);
            sxend_q <= XCOUNTER_BITS'(INIT_XEND);
            syon_q  <= YCOUNTER_BITS'(INIT_YON);
            syoff_q <= YCOUNTER_BITS'(INIT_YOFF);
            syend_q <= YCOUNTER_BITS'(INIT_YEND);
            pend_q  <= 1'b0;
        end else begin
            if (accept) begin
                if (c_last) begin
                    c_q <= '0;
                    if (x_last) begin
                        x_q <= '0;
                        y_q <= y_last ? '0 : y_q + 1'b1;
                    end else begin
                        x_q <= x_q + 1'b1;
                    end
                end else begin
                    c_q <= c_q + 1'b1;
                end
            end

            if (load) begin
                xon_q  <= sxon_q;
                xoff_q <= sxoff_q;
                xend_q <= sxend_q;
                yon_q  <= syon_q;
                yoff_q <= syoff_q;
                yend_q <= syend_q;
            end

            // A write coinciding with a reload still lands in staging, and
            // pending stays set so it is applied at the following boundary.
            if (we) begin
                case (wa[4:2])
                    3'd0: sxon_q  <= wd[XCOUNTER_BITS-1:0];
                    3'd1: sxoff_q <= wd[XCOUNTER_BITS-1:0];
                    3'd2: sxend_q <= wd[XCOUNTER_BITS-1:0];
                    3'd3: syon_q  <= wd[YCOUNTER_BITS-1:0];
                    3'd4: syoff_q <= wd[YCOUNTER_BITS-1:0];
                    3'd5: syend_q <= wd[YCOUNTER_BITS-1:0];
                    default: ;
                endcase
            end

            if (wr_hit) begin
                pend_q <= 1'b1;
            end else if (load) begin
                pend_q <= 1'b0;
            end
        end
    end

    // Push and pop with the buffer full cannot occur, because rdy_q is low then.
    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        skid_d = skid_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    head_d = s_axis_tdata;
                    cnt_d  = 2'd1;
                end else begin
                    skid_d = s_axis_tdata;
                    cnt_d  = 2'd2;
                end
            end
            2'b01: begin
                if (cnt_q == 2'd2) begin
                    head_d = skid_q;
                    cnt_d  = 2'd1;
                end else begin
                    cnt_d  = 2'd0;
                end
            end
            2'b11: begin
                head_d = s_axis_tdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            head_q <= '0;
            skid_q <= '0;
            cnt_q  <= 2'd0;
            vld_q  <= 1'b0;
            rdy_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            skid_q <= skid_d;
            cnt_q  <= cnt_d;
            vld_q  <= (cnt_d != 2'd0);
            rdy_q  <= (cnt_d != 2'd2);
        end
    end

    assign s_axis_tready = rdy_q;
    assign m_axis_tvalid = vld_q;
    assign m_axis_tdata  = head_q;

endmodule

// File: tb/tb_fmcrop.sv
// Self-checking bench for fmcrop. The default parameters are used: CF=2 and
// a 10x10 frame, so one frame is 200 beats and input beat n carries data n.
// A table of geometries is applied, one row per frame. Hand-written
// sequences then cover backpressure, a mid-frame reload, a degenerate
// window, writes to unmapped addresses and an asynchronous reset.
module tb_fmcrop;

    localparam int SB = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          we;
    logic [4:0]    wa;
    logic [31:0]   wd;
    logic          s_valid;
    logic [SB-1:0] s_data;
    logic          s_ready;
    logic          m_valid;
    logic [SB-1:0] m_data;
    bit            m_ready = 1'b1;

    bit rand_mode   = 1'b0;
    bit ready_level = 1'b1;

    int checks = 0;
    int errors = 0;

    int got[$];
    int exp_q[$];
    bit keep_map[0:255];
    int kept_acc = 0;
    int pops = 0;
    int stalls = 0;
    int occ_err = 0;
    int stable_err = 0;
    bit mon_en = 1'b0;
    bit held = 1'b0;
    logic [SB-1:0] held_data;

    typedef struct {
        int xon, xoff, xend, yon, yoff, yend;
        int ecnt, efirst, elast;
    } vec_t;

    vec_t tbl[9];

    fmcrop dut (
        .ap_clk        (clk),
        .ap_rst        (rst),
        .we            (we),
        .wa            (wa),
        .wd            (wd),
        .s_axis_tready (s_ready),
        .s_axis_tvalid (s_valid),
        .s_axis_tdata  (s_data),
        .m_axis_tready (m_ready),
        .m_axis_tvalid (m_valid),
        .m_axis_tdata  (m_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        m_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_level;
    end

    // Outputs are sampled on the falling edge. occ is the number of kept
    // beats accepted so far minus the number of beats popped.
    always @(negedge clk) begin
        int occ;
        if (mon_en && !rst) begin
            occ = kept_acc - pops;
            if (held && m_data != held_data) stable_err++;
            if (m_valid !== (occ != 0) || s_ready !== (occ != 2)) occ_err++;
            held = m_valid && !m_ready;
            held_data = m_data;
            if (m_valid && m_ready) begin
                got.push_back(int'(m_data));
                pops++;
            end
        end else begin
            held = 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic build_ref(input int xon, input int xoff, input int xend,
                             input int yon, input int yoff, input int yend);
        for (int i = 0; i < 256; i++) keep_map[i] = 1'b0;
        for (int y = 0; y <= yend; y++)
            for (int x = 0; x <= xend; x++)
                for (int c = 0; c < 2; c++) begin
                    int idx;
                    bit k;
                    idx = (y * (xend + 1) + x) * 2 + c;
                    k = (x >= xon) && (x < xoff) && (y >= yon) && (y < yoff);
                    keep_map[idx] = k;
                    if (k) exp_q.push_back(idx);
                end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        we = 1'b1;
        wa = addr;
        wd = data;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst = 1'b1;
        s_valid = 1'b0;
        we = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        kept_acc = 0;
        pops = 0;
        got.delete();
        exp_q.delete();
        mon_en = 1'b1;
    endtask

    // Streams beats 0..n-1. When wr_at >= 0, XON=0 is written while beat
    // wr_at is presented and XOFF=10 while the next beat is presented.
    task automatic run_frame(input int n, input int wr_at);
        for (int i = 0; i < n; i++) begin
            bit acc;
            acc = 1'b0;
            s_valid = 1'b1;
            s_data = SB'(i);
            if (i == wr_at) begin
                we = 1'b1; wa = 5'h00; wd = 32'd0;
            end else if (wr_at >= 0 && i == wr_at + 1) begin
                we = 1'b1; wa = 5'h04; wd = 32'd10;
            end else begin
                we = 1'b0;
            end
            for (int t = 0; t < 300 && !acc; t++) begin
                @(negedge clk);
                acc = s_ready;
                if (!acc) stalls++;
                @(posedge clk);
                #1;
                we = 1'b0;
            end
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: beat %0d not accepted, required accept within 300 cycles", i);
                s_valid = 1'b0;
                return;
            end
            if (keep_map[i]) kept_acc++;
        end
        s_valid = 1'b0;
        we = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 3000; t++) begin
            if (kept_acc == pops) break;
            @(negedge clk);
        end
        chk("drain", kept_acc - pops, 0);
        idle(2);
    endtask

    task automatic check_frame(input string name, input int ecnt,
                               input int efirst, input int elast);
        int mism;
        int n;
        mism = -1;
        chk({name, " count"}, got.size(), ecnt);
        if (ecnt > 0) begin
            chk({name, " first"}, (got.size() > 0) ? got[0] : -1, efirst);
            chk({name, " last"}, (got.size() > 0) ? got[got.size() - 1] : -1, elast);
        end
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (mism < 0 && got[i] != exp_q[i]) mism = i;
        if (mism < 0 && got.size() != exp_q.size()) mism = n;
        chk({name, " seq_first_mismatch"}, mism, -1);
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1, 9, 9, 1, 9, 9, 128, 22, 177};
        tbl[1] = '{0, 10, 9, 1, 9, 9, 160, 20, 179};
        tbl[2] = '{1, 9, 9, 5, 5, 9, 0, -1, -1};
        tbl[3] = '{3, 5, 9, 2, 4, 9, 8, 46, 69};
        tbl[4] = '{0, 3, 9, 0, 1, 9, 6, 0, 5};
        tbl[5] = '{8, 20, 9, 9, 12, 9, 4, 196, 199};
        tbl[6] = '{5, 2, 9, 0, 10, 9, 0, -1, -1};
        tbl[7] = '{1, 3, 4, 1, 2, 3, 4, 12, 15};
        tbl[8] = '{0, 5, 4, 0, 4, 3, 40, 0, 39};

        rst = 1'b1; we = 1'b0; wa = '0; wd = '0;
        s_valid = 1'b0; s_data = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst m_valid", int'(m_valid), 0);
        chk("rst m_data", int'(m_data), 0);
        chk("rst s_ready", int'(s_ready), 0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst s_ready", int'(s_ready), 1);
        chk("post_rst m_valid", int'(m_valid), 0);

        // Table: one geometry per frame, m_axis_tready held high
        for (int r = 0; r < 9; r++) begin
            vec_t v;
            v = tbl[r];
            do_reset();
            occ_err = 0;
            wr(5'h00, 32'(v.xon));
            wr(5'h04, 32'(v.xoff));
            wr(5'h08, 32'(v.xend));
            wr(5'h0C, 32'(v.yon));
            wr(5'h10, 32'(v.yoff));
            wr(5'h14, 32'(v.yend));
            idle(3);
            build_ref(v.xon, v.xoff, v.xend, v.yon, v.yoff, v.yend);
            stalls = 0;
            run_frame((v.xend + 1) * (v.yend + 1) * 2, -1);
            drain();
            check_frame($sformatf("row%0d", r), v.ecnt, v.efirst, v.elast);
            chk($sformatf("row%0d stalls", r), stalls, 0);
            chk($sformatf("row%0d occupancy", r), occ_err, 0);
        end

        // Random backpressure with the reset geometry
        do_reset();
        occ_err = 0;
        stable_err = 0;
        rand_mode = 1'b1;
        build_ref(1, 9, 9, 1, 9, 9);
        run_frame(200, -1);
        drain();
        rand_mode = 1'b0;
        idle(2);
        check_frame("bp", 128, 22, 177);
        chk("bp stable", stable_err, 0);
        chk("bp occupancy", occ_err, 0);

        // Mid-frame write, then a back-to-back second frame
        do_reset();
        occ_err = 0;
        build_ref(1, 9, 9, 1, 9, 9);
        run_frame(200, 50);
        build_ref(0, 10, 9, 1, 9, 9);
        run_frame(200, -1);
        drain();
        chk("mid f1 last", (got.size() > 128) ? got[127] : -1, 177);
        chk("mid f2 first", (got.size() > 128) ? got[128] : -1, 20);
        check_frame("mid", 288, 22, 179);
        chk("mid occupancy", occ_err, 0);

        // Degenerate Y window written between frames, without a reset
        wr(5'h0C, 32'd5);
        wr(5'h10, 32'd5);
        idle(3);
        build_ref(0, 10, 9, 5, 5, 9);
        stalls = 0;
        run_frame(200, -1);
        drain();
        check_frame("degen", 0, -1, -1);
        chk("degen stalls", stalls, 0);

        // Writes to the unused word addresses 6 and 7
        do_reset();
        wr(5'h18, 32'hFFFF_FFFF);
        wr(5'h1C, 32'h0000_0000);
        wr(5'h1F, 32'h0000_0003);
        idle(3);
        build_ref(1, 9, 9, 1, 9, 9);
        run_frame(200, -1);
        drain();
        check_frame("unmapped", 128, 22, 177);

        // Asynchronous reset with two beats buffered
        do_reset();
        ready_level = 1'b0;
        idle(2);
        build_ref(1, 9, 9, 1, 9, 9);
        run_frame(24, -1);
        idle(2);
        chk("arst full s_ready", int'(s_ready), 0);
        chk("arst full m_valid", int'(m_valid), 1);
        chk("arst full m_data", int'(m_data), 22);
        mon_en = 1'b0;
        @(posedge clk);
        #4 rst = 1'b1;
        #1;
        chk("arst m_valid", int'(m_valid), 0);
        chk("arst m_data", int'(m_data), 0);
        #12 rst = 1'b0;
        @(posedge clk);
        #1;
        ready_level = 1'b1;
        kept_acc = 0;
        pops = 0;
        got.delete();
        exp_q.delete();
        occ_err = 0;
        idle(2);
        mon_en = 1'b1;
        build_ref(1, 9, 9, 1, 9, 9);
        run_frame(200, -1);
        drain();
        check_frame("arst", 128, 22, 177);
        chk("arst occupancy", occ_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
